// File: rtl/video_pkg.sv
// Shared constants for the motion-object line buffer slice.
// Widths, transparent pixel code and buffer-select encoding.
package video_pkg;

  localparam int LB_XW = 8;
  localparam int LB_PW = 4;

  localparam logic [LB_PW-1:0] MO_TRANSPARENT = '0;

  localparam logic SEL_BUF0 = 1'b0;
  localparam logic SEL_BUF1 = 1'b1;

endpackage

// File: rtl/mo_lb_ram.sv
// 2^XW x PW simple dual-port RAM, registered read (read-first).
// Ports: clk; write we/wa/wd; read re/ra -> rd (one clk later).
module mo_lb_ram #(
  parameter int XW = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [XW-1:0] wa,
  input  logic [PW-1:0] wd,
  input  logic          re,
  input  logic [XW-1:0] ra,
  output logic [PW-1:0] rd
);

  logic [PW-1:0] mem [2**XW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/mo_line_buffer.sv
// Ping-pong motion-object line buffer feeding the colour memory.
// Ports: clk, reset, ce5, line_start, rd_x, wr_en/wr_x/wr_pix -> MV, init_busy.
module mo_line_buffer
  import video_pkg::*;
#(
  parameter int XW = LB_XW,
  parameter int PW = LB_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce5,
  input  logic          line_start,
  input  logic [XW-1:0] rd_x,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [PW-1:0] wr_pix,
  output logic [PW-1:0] MV,
  output logic          init_busy
);

  logic          sel;
  logic [XW-1:0] cnt;

  logic          rv;
  logic          rfresh;
  logic          rtag;
  logic [XW-1:0] ra;
  logic [PW-1:0] rhold;

  logic          s1v;
  logic          s1tag;
  logic [XW-1:0] s1x;
  logic [PW-1:0] s1pix;
  logic          s1fwd;
  logic [PW-1:0] s1fpix;

  logic [PW-1:0] q   [2];
  logic [1:0]    re;
  logic [XW-1:0] rda [2];
  logic [1:0]    we;
  logic [XW-1:0] wa  [2];
  logic [PW-1:0] wd  [2];

  logic          rd_go;
  logic          wr_go;
  logic          clr_go;
  logic          s1_wr;
  logic          fwd_hit;
  logic [PW-1:0] s1old;
  logic [PW-1:0] rdata;

  assign rd_go  = ce5 & ~init_busy;
  assign wr_go  = wr_en & ~init_busy;
  assign clr_go = rd_go & rv;

  assign s1old  = s1fwd ? s1fpix : q[s1tag];
  assign s1_wr  = s1v && (s1pix != MO_TRANSPARENT)
               && (s1old == MO_TRANSPARENT);

  assign fwd_hit = s1_wr && (s1x == wr_x) && (s1tag == ~sel);

  // Read data is only on the RAM port the clk after the read;
  // later a fill read may overwrite it, so it is parked in rhold.
  assign rdata = rfresh ? q[rtag] : rhold;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      re[b]  = 1'b0;
      rda[b] = rd_x;
      we[b]  = 1'b0;
      wa[b]  = cnt;
      wd[b]  = MO_TRANSPARENT;
      if (rd_go && sel == 1'(b)) begin
        re[b]  = 1'b1;
        rda[b] = rd_x;
      end else if (wr_go && sel != 1'(b)) begin
        re[b]  = 1'b1;
        rda[b] = wr_x;
      end
      // Fill write wins over a late clear landing in the same buffer.
      if (init_busy) begin
        we[b] = 1'b1;
        wa[b] = cnt;
        wd[b] = MO_TRANSPARENT;
      end else if (s1_wr && s1tag == 1'(b)) begin
        we[b] = 1'b1;
        wa[b] = s1x;
        wd[b] = s1pix;
      end else if (clr_go && rtag == 1'(b)) begin
        we[b] = 1'b1;
        wa[b] = ra;
        wd[b] = MO_TRANSPARENT;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ram
    mo_lb_ram #(
      .XW(XW),
      .PW(PW)
    ) u_ram (
      .clk(clk),
      .we (we[g]),
      .wa (wa[g]),
      .wd (wd[g]),
      .re (re[g]),
      .ra (rda[g]),
      .rd (q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= SEL_BUF0;
      MV        <= MO_TRANSPARENT;
      init_busy <= 1'b1;
      cnt       <= '0;
      rv        <= 1'b0;
      rfresh    <= 1'b0;
      rtag      <= SEL_BUF0;
      ra        <= '0;
      rhold     <= MO_TRANSPARENT;
      s1v       <= 1'b0;
      s1tag     <= SEL_BUF0;
      s1x       <= '0;
      s1pix     <= MO_TRANSPARENT;
      s1fwd     <= 1'b0;
      s1fpix    <= MO_TRANSPARENT;
    end else begin
      if (init_busy) begin
        cnt <= cnt + XW'(1);
        if (cnt == '1) init_busy <= 1'b0;
      end
      if (line_start && !init_busy) sel <= ~sel;

      rfresh <= rd_go;
      if (rfresh) rhold <= q[rtag];

      if (rd_go) begin
        MV   <= rv ? rdata : MO_TRANSPARENT;
        rv   <= 1'b1;
        ra   <= rd_x;
        rtag <= sel;
      end

      s1v <= wr_go;
      if (wr_go) begin
        s1tag  <= ~sel;
        s1x    <= wr_x;
        s1pix  <= wr_pix;
        s1fwd  <= fwd_hit;
        s1fpix <= s1pix;
      end
    end
  end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Randomised + directed bench for mo_line_buffer.
// Reference model: two pixel arrays updated per transaction.
module tb_mo_line_buffer;
  import video_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce5 = 1'b0;
  logic          line_start = 1'b0;
  logic [LB_XW-1:0] rd_x = '0;
  logic          wr_en = 1'b0;
  logic [LB_XW-1:0] wr_x = '0;
  logic [LB_PW-1:0] wr_pix = '0;
  logic [LB_PW-1:0] mv;
  logic          init_busy;

  int errs = 0;
  int checks = 0;

  logic [LB_PW-1:0] mb [2][256];
  int               msel = 0;
  int               busy_n = 0;
  bit               pv = 0;
  logic [LB_PW-1:0] pval = '0;
  int               pra = 0;
  int               ptag = 0;
  logic [LB_PW-1:0] exp_mv = '0;
  logic [LB_PW-1:0] got [256];

  always #5 clk = ~clk;

  mo_line_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .ce5       (ce5),
    .line_start(line_start),
    .rd_x      (rd_x),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_pix    (wr_pix),
    .MV        (mv),
    .init_busy (init_busy)
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(bit rst, bit c, bit ls, bit we,
                     int rx, int wx, int wp);
    logic [LB_PW-1:0] nv;
    @(negedge clk);
    reset      = rst;
    ce5        = c;
    line_start = ls;
    wr_en      = we;
    rd_x       = LB_XW'(rx);
    wr_x       = LB_XW'(wx);
    wr_pix     = LB_PW'(wp);
    if (rst) begin
      foreach (mb[b, i]) mb[b][i] = '0;
      msel = 0; busy_n = 256; pv = 0; exp_mv = '0;
    end else if (busy_n > 0) begin
      busy_n--;
    end else begin
      if (c) begin
        exp_mv = pv ? pval : '0;
        nv = mb[msel][rx];
        if (pv) mb[ptag][pra] = '0;
        pval = nv; pv = 1; pra = rx; ptag = msel;
      end
      if (we && wp != 0 && mb[1-msel][wx] == 0)
        mb[1-msel][wx] = LB_PW'(wp);
      if (ls) msel = 1 - msel;
    end
    @(posedge clk);
    #1;
    chk("mv", mv, exp_mv);
    chk("busy", init_busy, busy_n > 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic swap();
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic wr(int x, int p);
    cyc(0, 0, 0, 1, 0, x, p);
  endtask

  task automatic rwr();
    int x, p;
    x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                    : $urandom_range(100, 107);
    p = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
    wr(x, p);
  endtask

  task automatic sweep(bit rnd, int n);
    for (int i = 0; i <= n; i++) begin
      if (rnd && i > 0)
        while ($urandom_range(0, 2) == 0) rwr();
      cyc(0, 1, 0, 0, i % 256, 0, 0);
      if (i > 0) got[i-1] = mv;
    end
  endtask

  task automatic count_nz(input int skip, output int n);
    n = 0;
    foreach (got[i]) if (got[i] != 0 && i != skip) n++;
  endtask

  initial begin
    int n;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (256) idle();
    chk("busy_done", init_busy, 0);

    swap(); sweep(0, 256); count_nz(-1, n); chk("clr_a", n, 0);
    swap(); sweep(0, 256); count_nz(-1, n); chk("clr_b", n, 0);

    wr(10, 5);
    swap(); sweep(0, 256);
    chk("x10", got[10], 5);
    count_nz(10, n); chk("x10_only", n, 0);
    swap(); sweep(0, 256);
    swap(); sweep(0, 256);
    chk("x10_clr", got[10], 0);

    wr(20, 3); wr(20, 7);
    swap(); sweep(0, 256);
    chk("fwd_b2b", got[20], 3);
    swap(); sweep(0, 256);
    wr(20, 3); repeat (5) idle(); wr(20, 7);
    swap(); sweep(0, 256);
    chk("gap5", got[20], 3);

    swap(); sweep(0, 256);
    wr(30, 9); wr(30, 0); wr(40, 0);
    swap(); sweep(0, 256);
    chk("x30", got[30], 9);
    chk("x40", got[40], 0);

    swap(); sweep(0, 256);
    cyc(0, 0, 1, 1, 0, 50, 6);
    idle();
    sweep(0, 256);
    chk("ls_wr", got[50], 6);
    swap(); sweep(0, 256);
    chk("ls_other", got[50], 0);

    repeat (6) begin
      swap(); sweep(1, 256);
    end

    swap();
    sweep(1, 99);
    cyc(1, 1, 0, 1, 5, 100, 9);
    repeat (256)
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 15));
    chk("busy_rst", init_busy, 0);
    swap(); sweep(0, 256); count_nz(-1, n); chk("rst_clr_a", n, 0);
    swap(); sweep(0, 256); count_nz(-1, n); chk("rst_clr_b", n, 0);

    repeat (3) begin
      swap(); sweep(1, 256);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mo_line_buffer.md
Name: mo_line_buffer

Overview:
- Double-buffered (ping-pong) motion-object line buffer directly upstream of the colour-memory stage.
- While one 256x4 buffer is displayed, it drives MV[3:0] pixel by pixel and is cleared behind the read.
- The other buffer is filled by the motion-object engine for the next scanline. First-written opaque pixel wins.
- Swaps on each line_start pulse. Clears both buffers after reset.

Parameters:
- XW, 8, x-address width (buffer depth 2^XW = 256)
- PW, 4, pixel width (MV width)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce5  in  1  pixel clock enable (one clk pulse per pixel)
- line_start  in  1  one-clk pulse at start of horizontal blank; swaps buffers
- rd_x  in  XW  display x of the pixel being fetched; sampled on ce5
- wr_en  in  1  motion-object pixel write strobe; one per clk max, no backpressure
- wr_x  in  XW  write x position
- wr_pix  in  PW  pixel value; 0 = transparent
- MV  out  PW  motion-object pixel to colour memory
- init_busy  out  1  high during post-reset clear sweep

Behaviour:
- Storage: two 2^XW x PW dual-port synchronous RAMs, buf0 and buf1. Each has one read and one write per clk. sel is a register: display buffer = buf[sel], fill buffer = buf[~sel].
- Reset (any clk with reset=1): sel=0, MV=0, init_busy=1, clear counter=0, read and write pipelines invalid. Reset mid-line aborts everything in flight.
- Init sweep:
  - Starts the first clk after reset deasserts.
  - Writes 0 to address cnt in both buffers each clk.
  - Runs for 2^XW clks (cnt 0..255), then init_busy=0 on the next clk.
  - While init_busy: wr_en ignored, line_start ignored, MV held 0.
- Display read:
  - On a clk with ce5=1, the display buffer is read at rd_x and rd_x is latched as ra.
  - On the next ce5 clk, MV loads the RAM data and 0 is written to display buffer at ra (clear-after-read).
  - Latency: MV at pixel n reflects rd_x sampled at pixel n-1.
  - MV changes only on ce5 clks (or reset).
- Fill write pipeline:
  - Stage 0 (clk t, wr_en=1): read fill buffer at wr_x; latch x, pix and buffer tag = ~sel into s1.
  - Stage 1 (clk t+1): write pix to the tagged buffer at x only if pix!=0 and old value==0. Otherwise no write.
  - wr_pix=0 never writes.
- Forwarding:
  - If stage 1 writes address A of buffer B and stage 0 reads A of B in the same clk, stage 0 uses the forwarded pix.
  - Back-to-back writes to one x therefore keep the first opaque value.
- Swap:
  - On line_start=1 (init_busy=0), sel toggles at that clk edge.
  - wr_en on the same clk as line_start is tagged with the pre-swap fill buffer.
  - An in-flight stage-1 write always completes to its tagged buffer, even after a swap.
  - A display read issued on the swap clk uses the pre-swap display buffer. Its clear also goes to that tagged buffer.
- Simultaneous line_start and ce5: both act, per the tags above.
- Address wrap: x is XW bits, so 255+1 wraps to 0 naturally; no saturation.
- The clear-after-read guarantees a buffer is all-zero when it becomes the fill buffer, provided all 256 x positions are read during the display line.

Decomposition:
- Shared package (video_pkg): XW, PW, MO_TRANSPARENT=0, buffer-select encoding.
- Sub-module: mo_lb_ram, a 2^XW x PW simple dual-port RAM with registered read. Instantiated twice.
- Top holds sel, the init counter, the read/clear pipeline and the write pipeline with forwarding.

Test Plan:
- Reset then idle: MV=0, init_busy high exactly 256 clks then low. Read all 256 x of both buffers after two swaps -> all 0.
- Fill x=10 pix=5, line_start, display sweep rd_x 0..255 -> MV=5 only on the ce5 after rd_x=10 was sampled, 0 elsewhere. Next swap-back line reads x=10 -> 0 (cleared).
- Back-to-back wr_en x=20 pix=3 then x=20 pix=7 on consecutive clks (forwarding path) -> displayed value 3. Same pair separated by 5 clks -> 3.
- wr_en x=30 pix=0 after x=30 pix=9 -> 9. wr_en x=40 pix=0 alone -> 0.
- wr_en x=50 pix=6 on the same clk as line_start, then further line_start -> 6 appears on the line displayed from the pre-swap fill buffer, not the other.
- Assert reset mid-line while wr_en streaming and display active -> MV=0 next clk, sel=0, init sweep reruns, no stale pixel visible afterward.
